// File: rtl/ntt_pkg.sv
// Shared NTT parameters, zeta-stream FSM states and the built-in zeta table.
// The table is a closed-form function of the flat ROM index, so every consumer sees identical contents.
package ntt_pkg;

  localparam int    DATA_WIDTH    = 23;
  localparam int    NTT_STAGE_CNT = 8;
  localparam int    Q             = 8380417;
  localparam string ROM_PATH      = "rom";

  typedef enum logic [1:0] {ZS_IDLE, ZS_RUN, ZS_DRAIN} zs_state_t;

  // Flat-layout zeta word: word (1<<s)+k is zeta k of stage s; every word is nonzero and below Q.
  function automatic logic [DATA_WIDTH-1:0] zeta_rom_array(input logic [NTT_STAGE_CNT-1:0] idx);
    logic [DATA_WIDTH-1:0] w;
    w = {{(DATA_WIDTH-NTT_STAGE_CNT){1'b0}}, idx};
    return w * 23'd4099 + 23'd1;
  endfunction

endpackage

// File: rtl/zeta_stream_bank.sv
// zeta_bank: LANES-read-port synchronous zeta ROM with a shared read enable.
// Each port returns the addressed word one cycle after the address is presented.
module zeta_bank
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH    = ntt_pkg::DATA_WIDTH,
  parameter int NTT_STAGE_CNT = ntt_pkg::NTT_STAGE_CNT,
  parameter int LANES         = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_en,
  input  logic [LANES*NTT_STAGE_CNT-1:0]  rd_addr,
  output logic [LANES*DATA_WIDTH-1:0]     rd_data
);

  localparam int PKG_AW = ntt_pkg::NTT_STAGE_CNT;
  localparam int PKG_DW = ntt_pkg::DATA_WIDTH;

  logic [LANES*DATA_WIDTH-1:0] rd_data_r;

  // Registered read, one word per lane; held while the enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      for (int j = 0; j < LANES; j++) begin
        rd_data_r[j*DATA_WIDTH +: DATA_WIDTH] <=
          DATA_WIDTH'(zeta_rom_array(PKG_AW'(rd_addr[j*NTT_STAGE_CNT +: NTT_STAGE_CNT])));
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/zeta_stream.sv
// zeta_stream: self-timed twiddle sequencer emitting LANES zetas per beat in butterfly order.
// Pipeline: address issue -> synchronous ROM read -> negate/mask -> registered outputs; stall freezes everything.
module zeta_stream
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH    = ntt_pkg::DATA_WIDTH,
  parameter int NTT_STAGE_CNT = ntt_pkg::NTT_STAGE_CNT,
  parameter int LANES         = 2,
  parameter int Q             = ntt_pkg::Q
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               mode,
  input  logic                               stall,
  output logic                               busy,
  output logic                               zeta_valid,
  output logic [LANES-1:0]                   lane_valid,
  output logic [$clog2(NTT_STAGE_CNT)-1:0]   zeta_stage,
  output logic [LANES*DATA_WIDTH-1:0]        zeta_data,
  output logic                               done
);

  localparam int SW = $clog2(NTT_STAGE_CNT);
  localparam int AW = NTT_STAGE_CNT;
  localparam int KW = NTT_STAGE_CNT + 1;

  zs_state_t                   state_r, state_n_s;
  logic                        mode_r, mode_n_s;
  logic [SW-1:0]               stage_r, stage_n_s;
  logic signed [KW-1:0]        k_base_r, k_base_n_s;
  int                          span_s, kb_s;
  logic                        issue_s, last_s, stage_end_s, final_s;
  logic [LANES-1:0]            live_s;
  logic [LANES*AW-1:0]         rd_addr_s;
  logic [LANES*DATA_WIDTH-1:0] rom_data_s, out_data_s;

  logic                        v1_r, last1_r;
  logic [LANES-1:0]            live1_r;
  logic [SW-1:0]               stage1_r;

  logic                        busy_r, valid_r, done_r;
  logic [LANES-1:0]            lane_valid_r;
  logic [SW-1:0]               zeta_stage_r;
  logic [LANES*DATA_WIDTH-1:0] zeta_data_r;

  function automatic logic [DATA_WIDTH-1:0] neg_mod_q(input logic [DATA_WIDTH-1:0] w);
    return DATA_WIDTH'(Q) - w;
  endfunction

  assign span_s = 32'sd1 <<< stage_r;
  assign kb_s   = int'(k_base_r);

  // Lane index, liveness and flat ROM address for the current group
  always_comb begin
    int idx_v;
    idx_v     = 32'sd0;
    live_s    = '0;
    rd_addr_s = '0;
    for (int j = 0; j < LANES; j++) begin
      idx_v = mode_r ? kb_s - j : kb_s + j;
      if (idx_v >= 32'sd0 && idx_v < span_s) begin
        live_s[j]             = 1'b1;
        rd_addr_s[j*AW +: AW] = AW'(span_s + idx_v);
      end else begin
        live_s[j]             = 1'b0;
        rd_addr_s[j*AW +: AW] = '0;
      end
    end
  end

  // Sequencer next state: stage walk and k_base stepping
  always_comb begin
    state_n_s   = state_r;
    mode_n_s    = mode_r;
    stage_n_s   = stage_r;
    k_base_n_s  = k_base_r;
    issue_s     = 1'b0;
    last_s      = 1'b0;
    stage_end_s = mode_r ? (kb_s < LANES) : (kb_s + LANES >= span_s);
    final_s     = mode_r ? (stage_r == '0) : (stage_r == SW'(NTT_STAGE_CNT - 1));
    case (state_r)
      ZS_IDLE: begin
        if (start) begin
          state_n_s  = ZS_RUN;
          mode_n_s   = mode;
          stage_n_s  = mode ? SW'(NTT_STAGE_CNT - 1) : '0;
          k_base_n_s = mode ? KW'((32'sd1 <<< (NTT_STAGE_CNT - 1)) - 32'sd1) : '0;
        end else begin
          state_n_s = ZS_IDLE;
        end
      end
      ZS_RUN: begin
        issue_s = 1'b1;
        if (stage_end_s && final_s) begin
          state_n_s = ZS_DRAIN;
          last_s    = 1'b1;
        end else if (stage_end_s) begin
          stage_n_s  = mode_r ? stage_r - SW'(1) : stage_r + SW'(1);
          k_base_n_s = mode_r ? KW'((span_s >>> 1) - 32'sd1) : '0;
        end else begin
          k_base_n_s = mode_r ? k_base_r - KW'(LANES) : k_base_r + KW'(LANES);
        end
      end
      ZS_DRAIN: begin
        if (done_r) begin
          state_n_s = ZS_IDLE;
        end else begin
          state_n_s = ZS_DRAIN;
        end
      end
      default: state_n_s = ZS_IDLE;
    endcase
  end

  // Sequencer registers and issue-stage pipeline tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ZS_IDLE;
      mode_r   <= 1'b0;
      stage_r  <= '0;
      k_base_r <= '0;
      v1_r     <= 1'b0;
      live1_r  <= '0;
      stage1_r <= '0;
      last1_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else if (!stall) begin
      state_r  <= state_n_s;
      mode_r   <= mode_n_s;
      stage_r  <= stage_n_s;
      k_base_r <= k_base_n_s;
      v1_r     <= issue_s;
      live1_r  <= live_s;
      stage1_r <= stage_r;
      last1_r  <= last_s;
      busy_r   <= (state_n_s != ZS_IDLE);
    end
  end

  zeta_bank #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NTT_STAGE_CNT (NTT_STAGE_CNT),
    .LANES         (LANES)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (~stall),
    .rd_addr (rd_addr_s),
    .rd_data (rom_data_s)
  );

  // Inverse mode negates live lanes; dead lanes read zero
  always_comb begin
    out_data_s = '0;
    for (int j = 0; j < LANES; j++) begin
      if (live1_r[j]) begin
        out_data_s[j*DATA_WIDTH +: DATA_WIDTH] = mode_r ? neg_mod_q(rom_data_s[j*DATA_WIDTH +: DATA_WIDTH])
                                                        : rom_data_s[j*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        out_data_s[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r      <= 1'b0;
      lane_valid_r <= '0;
      zeta_stage_r <= '0;
      zeta_data_r  <= '0;
      done_r       <= 1'b0;
    end else if (!stall) begin
      valid_r      <= v1_r;
      lane_valid_r <= v1_r ? live1_r : '0;
      zeta_stage_r <= v1_r ? stage1_r : '0;
      zeta_data_r  <= v1_r ? out_data_s : '0;
      done_r       <= v1_r & last1_r;
    end
  end

  assign busy       = busy_r;
  assign zeta_valid = valid_r;
  assign lane_valid = lane_valid_r;
  assign zeta_stage = zeta_stage_r;
  assign zeta_data  = zeta_data_r;
  assign done       = done_r;

endmodule

// File: tb/tb_zeta_stream.sv
// Directed bench for zeta_stream: forward/inverse passes, stall, ignored start, mid-pass reset, LANES=4.
module tb_zeta_stream;

  localparam int QV = 8380417;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0, stall = 1'b0, start2 = 1'b0, start4 = 1'b0;

  logic        busy2, valid2, done2;
  logic [1:0]  lv2;
  logic [2:0]  st2;
  logic [45:0] d2;
  logic        busy4, valid4, done4;
  logic [3:0]  lv4;
  logic [2:0]  st4;
  logic [91:0] d4;

  zeta_stream #(.LANES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .stall(stall), .busy(busy2),
    .zeta_valid(valid2), .lane_valid(lv2), .zeta_stage(st2), .zeta_data(d2), .done(done2)
  );

  zeta_stream #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .stall(stall), .busy(busy4),
    .zeta_valid(valid4), .lane_valid(lv4), .zeta_stage(st4), .zeta_data(d4), .done(done4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [91:0] g_data[$], q_data[$];
  logic [3:0]  g_lv[$],   q_lv[$];
  logic [2:0]  g_st[$],   q_st[$];
  logic        g_dn[$],   q_dn[$];
  int          first_c, done_c, frozen_bad;
  logic        timeout, busy_at_done, pre_v;
  logic [53:0] rst_snap;

  function automatic logic [22:0] rom_w(input int i);
    return 23'(i * 4099 + 1);
  endfunction

  task automatic build_golden(input logic m, input int lanes);
    g_data.delete(); g_lv.delete(); g_st.delete(); g_dn.delete();
    for (int si = 0; si < 8; si++) begin
      int s, span, nb;
      s    = m ? 7 - si : si;
      span = 1 << s;
      nb   = (span < lanes) ? 1 : span / lanes;
      for (int b = 0; b < nb; b++) begin
        logic [91:0] d;
        logic [3:0]  lv;
        d  = '0;
        lv = '0;
        for (int j = 0; j < lanes; j++) begin
          int k;
          k = m ? span - 1 - b * lanes - j : b * lanes + j;
          if (k >= 0 && k < span) begin
            lv[j]         = 1'b1;
            d[j*23 +: 23] = m ? 23'(QV) - rom_w(span + k) : rom_w(span + k);
          end
        end
        g_data.push_back(d); g_lv.push_back(lv); g_st.push_back(3'(s)); g_dn.push_back(1'b0);
      end
    end
    g_dn[g_dn.size()-1] = 1'b1;
  endtask

  function automatic int beat_diffs();
    int n;
    n = (q_data.size() == g_data.size()) ? 0 : 1;
    for (int i = 0; i < q_data.size() && i < g_data.size(); i++)
      if (q_data[i] !== g_data[i] || q_lv[i] !== g_lv[i] || q_st[i] !== g_st[i] || q_dn[i] !== g_dn[i]) n++;
    return n;
  endfunction

  // Drives one pass and records every consumed beat; comparisons are made by the calling test.
  task automatic run_pass(input int lanes, input logic m, input int pre, input int s0, input int slen,
                          input int restart_c, input int rst_c);
    logic v, dn, bz;
    logic [3:0] lv;
    logic [2:0] st;
    logic [91:0] d;
    logic [99:0] snap;
    q_data.delete(); q_lv.delete(); q_st.delete(); q_dn.delete();
    first_c = -1; done_c = -1; frozen_bad = 0; timeout = 1'b1; busy_at_done = 1'b0; pre_v = 1'b0; snap = '0;
    @(negedge clk);
    mode  = m;
    stall = (pre > 0);
    if (lanes == 4) start4 = 1'b1; else start2 = 1'b1;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      v  = (lanes == 4) ? valid4 : valid2;
      lv = (lanes == 4) ? lv4 : {2'b00, lv2};
      st = (lanes == 4) ? st4 : st2;
      d  = (lanes == 4) ? d4 : {46'd0, d2};
      dn = (lanes == 4) ? done4 : done2;
      bz = (lanes == 4) ? busy4 : busy2;
      if (c == rst_c) begin
        pre_v = v;
        rst = 1'b1;
        #1;
        rst_snap = {busy2, valid2, lv2, st2, d2, done2};
        @(negedge clk);
        rst = 1'b0;
        timeout = 1'b0;
        break;
      end
      if (lanes == 4) start4 = (c <= pre) || (c == restart_c);
      else            start2 = (c <= pre) || (c == restart_c);
      stall = (c < pre) || (c >= s0 && c < s0 + slen);
      if (slen > 0 && c == s0) snap = {v, lv, st, d};
      if (slen > 0 && c > s0 && c <= s0 + slen && {v, lv, st, d} !== snap) frozen_bad++;
      if (v && !stall) begin
        q_data.push_back(d); q_lv.push_back(lv); q_st.push_back(st); q_dn.push_back(dn);
        if (first_c < 0) first_c = c;
      end
      if (dn && !stall) begin
        done_c = c; busy_at_done = bz; timeout = 1'b0;
        break;
      end
    end
    start2 = 1'b0; start4 = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy2, valid2, lv2, st2, d2, done2} !== '0) begin
      n_bad++; $display("FAIL reset_l2: got %h expected 0", {busy2, valid2, lv2, st2, d2, done2});
    end
    n_cmp++;
    if ({busy4, valid4, lv4, st4, d4, done4} !== '0) begin
      n_bad++; $display("FAIL reset_l4: got %h expected 0", {busy4, valid4, lv4, st4, d4, done4});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy2, valid2, done2} !== 3'b000) begin
      n_bad++; $display("FAIL reset_release: got %b expected 000", {busy2, valid2, done2});
    end
  endtask

  task automatic test_forward();
    build_golden(1'b0, 2);
    run_pass(2, 1'b0, 0, -1, 0, -1, -1);
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL fwd_timeout: got %b expected 0", timeout); end
    n_cmp++; if (q_data.size() != 128) begin n_bad++; $display("FAIL fwd_count: got %0d expected 128", q_data.size()); end
    n_cmp++; if (first_c != 3) begin n_bad++; $display("FAIL fwd_first_latency: got %0d expected 3", first_c); end
    n_cmp++; if (done_c != 130) begin n_bad++; $display("FAIL fwd_done_cycle: got %0d expected 130", done_c); end
    n_cmp++; if (busy_at_done !== 1'b1) begin n_bad++; $display("FAIL fwd_busy_at_done: got %b expected 1", busy_at_done); end
    n_cmp++; if (beat_diffs() != 0) begin n_bad++; $display("FAIL fwd_beats: got %0d differing beats expected 0", beat_diffs()); end
    n_cmp++;
    if (q_st[0] !== 3'd0 || q_lv[0] !== 4'b0001 || q_data[0] !== 92'd4100) begin
      n_bad++; $display("FAIL fwd_beat0: got st=%0d lv=%b d=%h expected st=0 lv=0001 d=1004", q_st[0], q_lv[0], q_data[0]);
    end
    n_cmp++;
    if (q_st[1] !== 3'd1 || q_data[1] !== {46'd0, 23'd12298, 23'd8199}) begin
      n_bad++; $display("FAIL fwd_beat1: got st=%0d d=%h expected st=1 {12298,8199}", q_st[1], q_data[1]);
    end
    n_cmp++;
    if (q_data[127] !== {46'd0, 23'd1045246, 23'd1041147} || q_dn[127] !== 1'b1) begin
      n_bad++; $display("FAIL fwd_last: got d=%h done=%b expected {1045246,1041147} done=1", q_data[127], q_dn[127]);
    end
    @(negedge clk);
    n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL fwd_busy_fall: got %b expected 0", busy2); end
  endtask

  task automatic test_inverse();
    build_golden(1'b1, 2);
    run_pass(2, 1'b1, 0, -1, 0, -1, -1);
    n_cmp++; if (q_data.size() != 128 || timeout !== 1'b0) begin n_bad++; $display("FAIL inv_count: got %0d expected 128", q_data.size()); end
    n_cmp++; if (beat_diffs() != 0) begin n_bad++; $display("FAIL inv_beats: got %0d differing beats expected 0", beat_diffs()); end
    n_cmp++;
    if (q_st[0] !== 3'd7 || q_lv[0] !== 4'b0011 || q_data[0] !== {46'd0, 23'd7339270, 23'd7335171}) begin
      n_bad++; $display("FAIL inv_first: got st=%0d lv=%b d=%h expected st=7 lv=0011 {7339270,7335171}", q_st[0], q_lv[0], q_data[0]);
    end
    n_cmp++;
    if (q_st[127] !== 3'd0 || q_lv[127] !== 4'b0001 || q_data[127] !== 92'd8376317) begin
      n_bad++; $display("FAIL inv_last: got st=%0d lv=%b d=%h expected st=0 lv=0001 d=8376317", q_st[127], q_lv[127], q_data[127]);
    end
  endtask

  task automatic test_stall();
    build_golden(1'b0, 2);
    run_pass(2, 1'b0, 0, 14, 5, -1, -1);
    n_cmp++; if (frozen_bad != 0) begin n_bad++; $display("FAIL stall_frozen: got %0d changed samples expected 0", frozen_bad); end
    n_cmp++; if (done_c != 135) begin n_bad++; $display("FAIL stall_done_cycle: got %0d expected 135", done_c); end
    n_cmp++; if (beat_diffs() != 0) begin n_bad++; $display("FAIL stall_beats: got %0d differing beats expected 0", beat_diffs()); end
    n_cmp++; if (q_st[11] !== 3'd4) begin n_bad++; $display("FAIL stall_stage: got %0d expected 4", q_st[11]); end
  endtask

  task automatic test_start_ignore();
    build_golden(1'b0, 2);
    run_pass(2, 1'b0, 3, -1, 0, 20, -1);
    n_cmp++; if (first_c != 6) begin n_bad++; $display("FAIL ign_first_latency: got %0d expected 6", first_c); end
    n_cmp++; if (done_c != 133) begin n_bad++; $display("FAIL ign_done_cycle: got %0d expected 133", done_c); end
    n_cmp++; if (beat_diffs() != 0) begin n_bad++; $display("FAIL ign_beats: got %0d differing beats expected 0", beat_diffs()); end
  endtask

  task automatic test_rst_mid();
    run_pass(2, 1'b0, 0, -1, 0, -1, 43);
    n_cmp++; if (pre_v !== 1'b1) begin n_bad++; $display("FAIL rst_mid_active: got valid=%b expected 1", pre_v); end
    n_cmp++; if (rst_snap !== '0) begin n_bad++; $display("FAIL rst_mid_async: got %h expected 0", rst_snap); end
    n_cmp++; if ({busy2, valid2} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_idle: got %b expected 00", {busy2, valid2}); end
    build_golden(1'b0, 2);
    run_pass(2, 1'b0, 0, -1, 0, -1, -1);
    n_cmp++; if (q_data.size() != 128 || beat_diffs() != 0) begin
      n_bad++; $display("FAIL rst_mid_repass: got %0d beats %0d diffs expected 128 beats 0 diffs", q_data.size(), beat_diffs());
    end
  endtask

  task automatic test_lanes4();
    int n7;
    build_golden(1'b0, 4);
    run_pass(4, 1'b0, 0, -1, 0, -1, -1);
    n7 = 0;
    foreach (q_st[i]) if (q_st[i] == 3'd7) n7++;
    n_cmp++; if (q_data.size() != 65) begin n_bad++; $display("FAIL l4_count: got %0d expected 65", q_data.size()); end
    n_cmp++; if (done_c != 67) begin n_bad++; $display("FAIL l4_done_cycle: got %0d expected 67", done_c); end
    n_cmp++; if (q_lv[0] !== 4'b0001 || q_lv[1] !== 4'b0011) begin
      n_bad++; $display("FAIL l4_masks: got %b %b expected 0001 0011", q_lv[0], q_lv[1]);
    end
    n_cmp++; if (n7 != 32) begin n_bad++; $display("FAIL l4_stage7_beats: got %0d expected 32", n7); end
    n_cmp++; if (beat_diffs() != 0) begin n_bad++; $display("FAIL l4_beats: got %0d differing beats expected 0", beat_diffs()); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_stall();
    test_start_ignore();
    test_rst_mid();
    test_lanes4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
